// File: rtl/wbuff_tap_loader.sv
`default_nettype none
// ============================================================================
//  Module   : wbuff_tap_loader
//  Purpose  : Weight-buffer tap loader. Accepts a valid/ready stream of raw
//             weights in column-major order (col0 tap0, col0 tap1, ...). For
//             each weight it computes the radix-4 Booth recoding (BPR) and,
//             optionally, the effective-term count (ETC). Results go into a
//             shadow tap bank. A swap copies the whole shadow bank into the
//             active bank, which drives the PE-array "from wbuff" buses.
//             Reloading therefore overlaps compute.
//  Option   : `define WBUFF_LOADER_ETC_CALC_EN to build the ETC logic and
//             storage. Without it, WETCs_fr_wbuff is constant 0.
//  Ports    : clk, rst_n          - clock, synchronous active-low reset
//             w_in_valid/ready    - weight beat handshake
//             w_in_data           - two's-complement weight
//             flush               - abandon the current shadow fill
//             swap                - request shadow->active copy
//             shadow_full         - shadow bank holds a complete set
//             active_valid        - active bank holds loaded weights
//             wreg_updated        - one-cycle pulse after the active bank changes
//             WRegs/WBPRs/WETCs_fr_wbuff - active weights / BPRs / ETCs;
//                                  per column, tap t sits at [t*W +: W]
//  Revision : 1.0 - initial release
// ============================================================================
module wbuff_tap_loader #(
   parameter int NUM_PE_COL       = 16,
   parameter int NB_TAPS          = 11,
   parameter int USED_TAPS        = 3,
   parameter int WEIGHT_WIDTH     = 16,
   parameter int WEIGHT_BPR_WIDTH = ((WEIGHT_WIDTH + 1) / 2) * 3,
   parameter int ETC_WIDTH        = 4
) (
   input  logic                                           clk,
   input  logic                                           rst_n,
   input  logic                                           w_in_valid,
   output logic                                           w_in_ready,
   input  logic [WEIGHT_WIDTH-1:0]                        w_in_data,
   input  logic                                           flush,
   input  logic                                           swap,
   output logic                                           shadow_full,
   output logic                                           active_valid,
   output logic                                           wreg_updated,
   output logic [NUM_PE_COL*WEIGHT_WIDTH*NB_TAPS-1:0]     WRegs_fr_wbuff,
   output logic [NUM_PE_COL*WEIGHT_BPR_WIDTH*NB_TAPS-1:0] WBPRs_fr_wbuff,
   output logic [NUM_PE_COL*ETC_WIDTH*NB_TAPS-1:0]        WETCs_fr_wbuff
);

   localparam int COL_CW = (NUM_PE_COL > 1) ? $clog2(NUM_PE_COL) : 1;
   localparam int TAP_CW = (USED_TAPS > 1) ? $clog2(USED_TAPS) : 1;
   localparam int NGRP   = WEIGHT_WIDTH / 2;

   localparam logic [COL_CW-1:0] COL_LAST = COL_CW'(NUM_PE_COL - 1);
   localparam logic [TAP_CW-1:0] TAP_LAST = TAP_CW'(USED_TAPS - 1);

   localparam logic [0:0] S_FILL = 1'b0;
   localparam logic [0:0] S_FULL = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [COL_CW-1:0] col_cnt_q, col_cnt_d;
   logic [TAP_CW-1:0] tap_cnt_q, tap_cnt_d;
   logic              active_valid_q;
   logic              wreg_updated_q;

   logic [WEIGHT_WIDTH-1:0]     sh_w_q    [NUM_PE_COL][USED_TAPS];
   logic [WEIGHT_BPR_WIDTH-1:0] sh_bpr_q  [NUM_PE_COL][USED_TAPS];
   logic [WEIGHT_WIDTH-1:0]     act_w_q   [NUM_PE_COL][USED_TAPS];
   logic [WEIGHT_BPR_WIDTH-1:0] act_bpr_q [NUM_PE_COL][USED_TAPS];

   logic                        w_hs;
   logic                        w_wr;
   logic                        w_swap_fire;
   logic [WEIGHT_WIDTH:0]       w_ext;
   logic [WEIGHT_BPR_WIDTH-1:0] w_bpr;

   // Ready is held low while reset is asserted, so no beat is taken during reset.
   assign w_in_ready  = rst_n & (state_q == S_FILL);
   assign w_hs        = w_in_valid & w_in_ready;
   // Flush takes priority over both a handshake and a swap.
   assign w_wr        = w_hs & ~flush;
   assign w_swap_fire = (state_q == S_FULL) & swap & ~flush;

   assign shadow_full  = (state_q == S_FULL);
   assign active_valid = active_valid_q;
   assign wreg_updated = wreg_updated_q;

   // Booth group i is {w[2i+1], w[2i], w[2i-1]}. Appending a zero below the
   // LSB supplies w[-1] = 0, so each group becomes a plain 3-bit slice.
   assign w_ext = {w_in_data, 1'b0};

   for (genvar g = 0; g < NGRP; g++) begin : g_bpr
      assign w_bpr[3*g +: 3] = w_ext[2*g +: 3];
   end

   // ------------------------------------------------------------------------
   // Fill control
   // ------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      col_cnt_d = col_cnt_q;
      tap_cnt_d = tap_cnt_q;
      if (flush) begin
         state_d   = S_FILL;
         col_cnt_d = '0;
         tap_cnt_d = '0;
      end else if (state_q == S_FILL) begin
         if (w_hs) begin
            if (tap_cnt_q == TAP_LAST) begin
               tap_cnt_d = '0;
               if (col_cnt_q == COL_LAST) begin
                  col_cnt_d = '0;
                  state_d   = S_FULL;
               end else begin
                  col_cnt_d = col_cnt_q + COL_CW'(1);
               end
            end else begin
               tap_cnt_d = tap_cnt_q + TAP_CW'(1);
            end
         end
      end else if (swap) begin
         state_d = S_FILL;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= S_FILL;
         col_cnt_q      <= '0;
         tap_cnt_q      <= '0;
         active_valid_q <= 1'b0;
         wreg_updated_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         col_cnt_q      <= col_cnt_d;
         tap_cnt_q      <= tap_cnt_d;
         wreg_updated_q <= w_swap_fire;
         if (w_swap_fire) begin
            active_valid_q <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Shadow and active banks (weights and BPRs)
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int c = 0; c < NUM_PE_COL; c++) begin
            for (int t = 0; t < USED_TAPS; t++) begin
               sh_w_q[c][t]   <= '0;
               sh_bpr_q[c][t] <= '0;
            end
         end
      end else if (w_wr) begin
         sh_w_q[col_cnt_q][tap_cnt_q]   <= w_in_data;
         sh_bpr_q[col_cnt_q][tap_cnt_q] <= w_bpr;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int c = 0; c < NUM_PE_COL; c++) begin
            for (int t = 0; t < USED_TAPS; t++) begin
               act_w_q[c][t]   <= '0;
               act_bpr_q[c][t] <= '0;
            end
         end
      end else if (w_swap_fire) begin
         act_w_q   <= sh_w_q;
         act_bpr_q <= sh_bpr_q;
      end
   end

`ifdef WBUFF_LOADER_ETC_CALC_EN
   // ------------------------------------------------------------------------
   // Effective-term count: Booth groups 000 and 111 encode a zero digit, and
   // every other group contributes one partial product.
   // ------------------------------------------------------------------------
   logic [ETC_WIDTH-1:0] w_etc;
   logic [ETC_WIDTH-1:0] sh_etc_q  [NUM_PE_COL][USED_TAPS];
   logic [ETC_WIDTH-1:0] act_etc_q [NUM_PE_COL][USED_TAPS];

   always_comb begin
      w_etc = '0;
      for (int g = 0; g < NGRP; g++) begin
         if ((w_bpr[3*g +: 3] != 3'b000) && (w_bpr[3*g +: 3] != 3'b111)) begin
            w_etc = w_etc + ETC_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int c = 0; c < NUM_PE_COL; c++) begin
            for (int t = 0; t < USED_TAPS; t++) begin
               sh_etc_q[c][t]  <= '0;
               act_etc_q[c][t] <= '0;
            end
         end
      end else begin
         if (w_wr) begin
            sh_etc_q[col_cnt_q][tap_cnt_q] <= w_etc;
         end
         if (w_swap_fire) begin
            act_etc_q <= sh_etc_q;
         end
      end
   end
`endif

   // ------------------------------------------------------------------------
   // Output buses: loaded taps come from the active bank; the rest are tied 0
   // ------------------------------------------------------------------------
   for (genvar c = 0; c < NUM_PE_COL; c++) begin : g_col
      for (genvar t = 0; t < NB_TAPS; t++) begin : g_tap
         if (t < USED_TAPS) begin : g_used
            assign WRegs_fr_wbuff[(c*NB_TAPS+t)*WEIGHT_WIDTH +: WEIGHT_WIDTH]         = act_w_q[c][t];
            assign WBPRs_fr_wbuff[(c*NB_TAPS+t)*WEIGHT_BPR_WIDTH +: WEIGHT_BPR_WIDTH] = act_bpr_q[c][t];
`ifdef WBUFF_LOADER_ETC_CALC_EN
            assign WETCs_fr_wbuff[(c*NB_TAPS+t)*ETC_WIDTH +: ETC_WIDTH]               = act_etc_q[c][t];
`else
            assign WETCs_fr_wbuff[(c*NB_TAPS+t)*ETC_WIDTH +: ETC_WIDTH]               = '0;
`endif
         end else begin : g_unused
            assign WRegs_fr_wbuff[(c*NB_TAPS+t)*WEIGHT_WIDTH +: WEIGHT_WIDTH]         = '0;
            assign WBPRs_fr_wbuff[(c*NB_TAPS+t)*WEIGHT_BPR_WIDTH +: WEIGHT_BPR_WIDTH] = '0;
            assign WETCs_fr_wbuff[(c*NB_TAPS+t)*ETC_WIDTH +: ETC_WIDTH]               = '0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_wbuff_tap_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wbuff_tap_loader
//  Purpose  : Directed-vector bench for wbuff_tap_loader. Each expected
//             active bank is queued when its swap is issued. A monitor pops
//             the queue on every wreg_updated pulse and compares the buses.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_wbuff_tap_loader;

   localparam int NC   = 16;
   localparam int NT   = 11;
   localparam int UT   = 3;
   localparam int WW   = 16;
   localparam int BW   = 24;
   localparam int EW   = 4;
   localparam int WBUS = NC*WW*NT;
   localparam int BBUS = NC*BW*NT;
   localparam int EBUS = NC*EW*NT;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            w_in_valid = 1'b0;
   logic [WW-1:0]   w_in_data = '0;
   logic            flush = 1'b0;
   logic            swap = 1'b0;
   logic            w_in_ready;
   logic            shadow_full;
   logic            active_valid;
   logic            wreg_updated;
   logic [WBUS-1:0] WRegs_fr_wbuff;
   logic [BBUS-1:0] WBPRs_fr_wbuff;
   logic [EBUS-1:0] WETCs_fr_wbuff;

   wbuff_tap_loader #(
      .NUM_PE_COL(NC), .NB_TAPS(NT), .USED_TAPS(UT),
      .WEIGHT_WIDTH(WW), .WEIGHT_BPR_WIDTH(BW), .ETC_WIDTH(EW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .w_in_valid(w_in_valid), .w_in_ready(w_in_ready), .w_in_data(w_in_data),
      .flush(flush), .swap(swap),
      .shadow_full(shadow_full), .active_valid(active_valid), .wreg_updated(wreg_updated),
      .WRegs_fr_wbuff(WRegs_fr_wbuff), .WBPRs_fr_wbuff(WBPRs_fr_wbuff), .WETCs_fr_wbuff(WETCs_fr_wbuff)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic swap_hold = 1'b0;

   logic [WW-1:0]   cur [NC][UT];
   logic [WBUS-1:0] act_w_exp = '0;
   logic [BBUS-1:0] act_b_exp = '0;
   logic [EBUS-1:0] act_e_exp = '0;
   logic [WBUS-1:0] q_w [$];
   logic [BBUS-1:0] q_b [$];
   logic [EBUS-1:0] q_e [$];

   // Booth recoding from the bit definition: group i = {w[2i+1], w[2i], w[2i-1]}.
   function automatic logic [BW-1:0] ref_bpr(input logic [WW-1:0] w);
      logic [BW-1:0] r;
      r = '0;
      for (int i = 0; i < WW/2; i++) begin
         r[3*i+2] = w[2*i+1];
         r[3*i+1] = w[2*i];
         if (i > 0) r[3*i] = w[2*i-1];
      end
      return r;
   endfunction

   // ETC as the number of non-zero Booth digits d = -2*w[2i+1] + w[2i] + w[2i-1].
   function automatic logic [EW-1:0] ref_etc(input logic [WW-1:0] w);
      int n;
      int d;
      n = 0;
      for (int i = 0; i < WW/2; i++) begin
         d = -2*int'(w[2*i+1]) + int'(w[2*i]);
         if (i > 0) d = d + int'(w[2*i-1]);
         if (d != 0) n++;
      end
`ifdef WBUFF_LOADER_ETC_CALC_EN
      return EW'(n);
`else
      return (n < 0) ? EW'(1) : '0;
`endif
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic chk_vec(input string name, input logic [BBUS-1:0] a, input logic [BBUS-1:0] e, input int fw);
      int s;
      logic [31:0] fa;
      logic [31:0] fe;
      checks++;
      if (a !== e) begin
         errors++;
         s = 0;
         for (int b = 0; b < BBUS; b++) begin
            if (a[b] !== e[b]) begin
               s = b / fw;
               break;
            end
         end
         fa = '0;
         fe = '0;
         for (int k = 0; k < fw; k++) begin
            fa[k] = a[s*fw+k];
            fe[k] = e[s*fw+k];
         end
         $display("FAIL %s: col %0d tap %0d got %0h required %0h", name, s/NT, s%NT, fa, fe);
      end
   endtask

   task automatic chk_active(input string name);
      chk_vec({name, "_wregs"}, BBUS'(WRegs_fr_wbuff), BBUS'(act_w_exp), WW);
      chk_vec({name, "_wbprs"}, WBPRs_fr_wbuff,        act_b_exp,        BW);
      chk_vec({name, "_wetcs"}, BBUS'(WETCs_fr_wbuff), BBUS'(act_e_exp), EW);
   endtask

   task automatic fill_cur(input logic [WW-1:0] base, input int mul);
      for (int c = 0; c < NC; c++)
         for (int t = 0; t < UT; t++)
            cur[c][t] = base + WW'((c*UT + t) * mul);
   endtask

   task automatic push_expected();
      logic [WBUS-1:0] ew;
      logic [BBUS-1:0] eb;
      logic [EBUS-1:0] ee;
      ew = '0; eb = '0; ee = '0;
      for (int c = 0; c < NC; c++) begin
         for (int t = 0; t < UT; t++) begin
            ew[(c*NT+t)*WW +: WW] = cur[c][t];
            eb[(c*NT+t)*BW +: BW] = ref_bpr(cur[c][t]);
            ee[(c*NT+t)*EW +: EW] = ref_etc(cur[c][t]);
         end
      end
      q_w.push_back(ew);
      q_b.push_back(eb);
      q_e.push_back(ee);
   endtask

   // All stimulus tasks start and end just after a falling edge.
   task automatic idle(input int n);
      w_in_valid = 1'b0;
      swap       = swap_hold;
      flush      = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_beat(input logic [WW-1:0] d, input logic sw, input logic fl);
      int guard;
      guard      = 0;
      w_in_valid = 1'b1;
      w_in_data  = d;
      swap       = sw | swap_hold;
      flush      = fl;
      while (!w_in_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 200) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: w_in_ready=0 after %0d cycles, required 1", guard);
      end
      @(negedge clk);
   endtask

   task automatic load_set(input int first, input int last, input bit gaps, input int sw_a, input int sw_b);
      for (int k = first; k < last; k++) begin
         if (gaps && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
         send_beat(cur[k/UT][k%UT], (k == sw_a) || (k == sw_b), 1'b0);
      end
   endtask

   task automatic do_swap(input bit expect_copy);
      if (expect_copy) push_expected();
      w_in_valid = 1'b0;
      flush      = 1'b0;
      swap       = 1'b1;
      @(negedge clk);
      swap       = swap_hold;
   endtask

   task automatic clear_model();
      act_w_exp = '0;
      act_b_exp = '0;
      act_e_exp = '0;
      q_w.delete();
      q_b.delete();
      q_e.delete();
   endtask

   // Monitor: samples 1 ns after each rising edge.
   always begin
      @(posedge clk);
      #1;
      if (rst_n && wreg_updated === 1'b1) begin
         if (q_w.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: wreg_updated=1 required 0");
         end else begin
            act_w_exp = q_w.pop_front();
            act_b_exp = q_b.pop_front();
            act_e_exp = q_e.pop_front();
            chk_active("swap_copy");
            chk("active_valid_on_pulse", active_valid, 1);
            chk("shadow_full_on_pulse", shadow_full, 0);
         end
      end
   end

   initial begin
      logic z;
      logic [EW-1:0] etc1;
      logic [EW-1:0] etc8;
`ifdef WBUFF_LOADER_ETC_CALC_EN
      etc1 = 4'd1;
      etc8 = 4'd8;
`else
      etc1 = 4'd0;
      etc8 = 4'd0;
`endif
      // ---- reset state ----
      repeat (3) @(negedge clk);
      chk("rst_shadow_full", shadow_full, 0);
      chk("rst_active_valid", active_valid, 0);
      chk("rst_wreg_updated", wreg_updated, 0);
      chk_active("rst_buses");
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", w_in_ready, 1);

      // ---- 1: basic load, w = col*3 + tap ----
      fill_cur(16'h0000, 1);
      load_set(0, 47, 1'b0, -1, -1);
      chk("t1_not_full_at_47", shadow_full, 0);
      load_set(47, 48, 1'b0, -1, -1);
      chk("t1_full_after_48", shadow_full, 1);
      chk("t1_ready_low_full", w_in_ready, 0);
      do_swap(1'b1);
      idle(1);
      chk("t1_pulse_one_cycle", wreg_updated, 0);
      chk("t1_queue_drained", q_w.size(), 0);
      chk("t1_col5_tap2", WRegs_fr_wbuff[(5*NT+2)*WW +: WW], 17);
      z = 1'b1;
      for (int c = 0; c < NC; c++)
         for (int t = UT; t < NT; t++)
            if (WRegs_fr_wbuff[(c*NT+t)*WW +: WW] != 0 || WBPRs_fr_wbuff[(c*NT+t)*BW +: BW] != 0 ||
                WETCs_fr_wbuff[(c*NT+t)*EW +: EW] != 0) z = 1'b0;
      chk("t1_unused_taps_zero", z, 1);

      // ---- 2: Booth corner weights ----
      fill_cur(16'h0100, 7);
      cur[0][0] = 16'h8000;
      cur[0][1] = 16'hFFFF;
      cur[0][2] = 16'h5555;
      load_set(0, 48, 1'b0, -1, -1);
      do_swap(1'b1);
      idle(1);
      chk("t2_bpr_8000", WBPRs_fr_wbuff[0*BW +: BW], 24'h800000);
      chk("t2_etc_8000", WETCs_fr_wbuff[0*EW +: EW], etc1);
      chk("t2_bpr_ffff", WBPRs_fr_wbuff[1*BW +: BW], 24'hFFFFFE);
      chk("t2_etc_ffff", WETCs_fr_wbuff[1*EW +: EW], etc1);
      chk("t2_bpr_5555", WBPRs_fr_wbuff[2*BW +: BW], 24'h492492);
      chk("t2_etc_5555", WETCs_fr_wbuff[2*EW +: EW], etc8);

      // ---- 3: swap during FILL and on the final beat is ignored ----
      fill_cur(16'hA000, 3);
      load_set(0, 48, 1'b0, 19, 47);
      chk("t3_full_after_late_swap", shadow_full, 1);
      idle(1);
      chk_active("t3_active_held");
      do_swap(1'b1);
      idle(1);
      chk("t3_queue_drained", q_w.size(), 0);

      // ---- 4: flush mid-fill (with a dropped beat), flush+swap in FULL ----
      fill_cur(16'h3000, 1);
      load_set(0, 30, 1'b0, -1, -1);
      send_beat(16'hDEAD, 1'b0, 1'b1);
      chk("t4_not_full_after_flush", shadow_full, 0);
      chk_active("t4_active_after_flush");
      fill_cur(16'h4321, 5);
      load_set(0, 48, 1'b0, -1, -1);
      chk("t4_full", shadow_full, 1);
      chk_active("t4_active_before_swap");
      w_in_valid = 1'b0;
      flush      = 1'b1;
      swap       = 1'b1;
      @(negedge clk);
      idle(1);
      chk("t4_flush_in_full_clears", shadow_full, 0);
      chk("t4_ready_after_flush", w_in_ready, 1);
      chk_active("t4_active_after_flush_swap");
      load_set(0, 48, 1'b0, -1, -1);
      do_swap(1'b1);
      idle(1);
      chk("t4_queue_drained", q_w.size(), 0);

      // ---- 5: gapped valid, hold in FULL, then swap held high ----
      fill_cur(16'h7700, 11);
      load_set(0, 48, 1'b1, -1, -1);
      w_in_valid = 1'b1;
      w_in_data  = 16'hBEEF;
      repeat (5) begin
         @(negedge clk);
         chk("t5_ready_low_in_full", w_in_ready, 0);
      end
      chk_active("t5_active_held");
      do_swap(1'b1);
      idle(1);
      fill_cur(16'hC001, 13);
      push_expected();
      swap_hold = 1'b1;
      load_set(0, 48, 1'b1, -1, -1);
      idle(4);
      swap_hold = 1'b0;
      idle(2);
      chk("t5_single_copy_held_swap", q_w.size(), 0);
      chk_active("t5_active_after_held");

      // ---- 6: reset mid-fill ----
      fill_cur(16'h2468, 9);
      load_set(0, 24, 1'b0, -1, -1);
      rst_n      = 1'b0;
      w_in_valid = 1'b1;
      w_in_data  = cur[8][0];
      clear_model();
      repeat (2) @(negedge clk);
      chk("t6_rst_active_valid", active_valid, 0);
      chk("t6_rst_shadow_full", shadow_full, 0);
      chk("t6_rst_wreg_updated", wreg_updated, 0);
      chk_active("t6_rst_buses");
      rst_n = 1'b1;
      idle(1);
      fill_cur(16'h1357, 17);
      load_set(0, 47, 1'b0, -1, -1);
      chk("t6_not_full_at_47", shadow_full, 0);
      load_set(47, 48, 1'b0, -1, -1);
      chk("t6_full_after_48", shadow_full, 1);
      do_swap(1'b1);
      idle(2);
      chk("t6_queue_drained", q_w.size(), 0);
      chk("t6_active_valid", active_valid, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation still running, required completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
